// File: rtl/param_rv_fifo_pkg.sv
// Shared definitions for param_rv_fifo: read-mode constants, clog2 and
// elaboration-time parameter legality checks.
package fifo_defs;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/param_rv_fifo_ram.sv
// Width x Depth storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int Width     = 8,
  parameter int Depth     = 16,
  parameter int AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_rv_fifo.sv
// Parametrised ready/valid FIFO with FWFT or standard read mode, almost
// thresholds, write acknowledge and sticky overflow/underflow flags.
module param_rv_fifo
  import fifo_defs::*;
#(
  parameter int  Width             = 8,
  parameter int  Depth             = 16,
  parameter int  FWFT              = FIFO_MODE_FWFT,
  parameter int  AlmostFullThresh  = 14,
  parameter int  AlmostEmptyThresh = 2,
  localparam int CountWidth        = clog2(Depth) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [Width-1:0]      InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [Width-1:0]      OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [CountWidth-1:0] Count,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic                  WrAck,
  output logic                  Overflow,
  output logic                  Underflow,
  input  logic                  ClearFlags
);

  localparam int AddrWidth = clog2(Depth);

  if (!depth_ok(Depth)) begin : g_bad_depth
    $error("param_rv_fifo: Depth must be a power of two and at least 2");
  end
  if (!thresholds_ok(Depth, AlmostFullThresh, AlmostEmptyThresh)) begin : g_bad_thresh
    $error("param_rv_fifo: almost-full/almost-empty threshold out of range");
  end

  logic [CountWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  wr_ack_q, ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, wr_en, pop;
  logic [Width-1:0]      head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]) &&
                 (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]);
  assign wr_en = InValid && !full;
  assign pop   = OutReady && !empty;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + CountWidth'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + CountWidth'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
    // A new event in the same cycle as ClearFlags keeps the flag set.
    ovf_d = (ovf_q && !ClearFlags) || (InValid && full);
    udf_d = (udf_q && !ClearFlags) || (OutReady && empty);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_en;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .Width    (Width),
    .Depth    (Depth),
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clk_i  (Clock),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q[AddrWidth-1:0]),
    .wdata_i(InData),
    .raddr_i(rd_ptr_q[AddrWidth-1:0]),
    .rdata_o(head)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign OutValid = !empty;
    assign OutData  = head;
  end else begin : g_std
    logic [Width-1:0] out_data_q;
    logic             out_valid_q;

    // Data register is not reset; it simply holds the last popped entry.
    always_ff @(posedge Clock) begin
      if (!Reset) out_valid_q <= 1'b0;
      else        out_valid_q <= pop;
      if (Reset && pop) out_data_q <= head;
    end

    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
  end

  assign InReady     = !full;
  assign Count       = count_q;
  assign AlmostFull  = (count_q >= CountWidth'(AlmostFullThresh));
  assign AlmostEmpty = (count_q <= CountWidth'(AlmostEmptyThresh));
  assign WrAck       = wr_ack_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;

endmodule

// File: tb/tb_param_rv_fifo.sv
// Self-checking bench: an FWFT instance and a standard-mode instance, each
// compared every cycle against a queue-based model, plus directed literal checks.
module tb_param_rv_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] ind   [2];
  logic       inv   [2];
  logic       ordy  [2];
  logic       clr   [2];
  logic       inrdy [2];
  logic [7:0] outd  [2];
  logic       outv  [2];
  logic [4:0] cnt   [2];
  logic       af    [2];
  logic       ae    [2];
  logic       wack  [2];
  logic       ovf   [2];
  logic       udf   [2];

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  logic [7:0] mq [2][$];
  bit         m_wack [2];
  bit         m_ovf  [2];
  bit         m_udf  [2];
  bit         m_sov  [2];
  logic [7:0] m_sod  [2];
  bit         m_sod_known [2];
  bit         live = 0;

  param_rv_fifo #(.Width(8), .Depth(DEPTH), .FWFT(1), .AlmostFullThresh(14),
                  .AlmostEmptyThresh(2)) u_fwft (
    .Clock(clk), .Reset(rst_n), .InData(ind[0]), .InValid(inv[0]), .InReady(inrdy[0]),
    .OutData(outd[0]), .OutValid(outv[0]), .OutReady(ordy[0]), .Count(cnt[0]),
    .AlmostFull(af[0]), .AlmostEmpty(ae[0]), .WrAck(wack[0]), .Overflow(ovf[0]),
    .Underflow(udf[0]), .ClearFlags(clr[0]));

  param_rv_fifo #(.Width(8), .Depth(DEPTH), .FWFT(0), .AlmostFullThresh(14),
                  .AlmostEmptyThresh(2)) u_std (
    .Clock(clk), .Reset(rst_n), .InData(ind[1]), .InValid(inv[1]), .InReady(inrdy[1]),
    .OutData(outd[1]), .OutValid(outv[1]), .OutReady(ordy[1]), .Count(cnt[1]),
    .AlmostFull(af[1]), .AlmostEmpty(ae[1]), .WrAck(wack[1]), .Overflow(ovf[1]),
    .Underflow(udf[1]), .ClearFlags(clr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model update at each rising edge from the inputs held since the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          mq[k].delete();
          m_wack[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_sov[k] = 0;
        end else begin
          int  sz;
          bit  wr, pp;
          sz = mq[k].size();
          wr = inv[k] && (sz < DEPTH);
          pp = ordy[k] && (sz > 0);
          m_wack[k] = wr;
          if (clr[k]) begin m_ovf[k] = 0; m_udf[k] = 0; end
          if (inv[k] && sz == DEPTH) m_ovf[k] = 1;
          if (ordy[k] && sz == 0) m_udf[k] = 1;
          m_sov[k] = pp;
          if (pp) begin
            m_sod[k] = mq[k][0];
            m_sod_known[k] = 1;
            void'(mq[k].pop_front());
          end
          if (wr) mq[k].push_back(ind[k]);
        end
      end
      if (!rst_n) live = 1;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        for (int k = 0; k < 2; k++) begin
          int sz;
          sz = mq[k].size();
          check($sformatf("count[%0d]", k), 32'(cnt[k]), 32'(sz));
          check($sformatf("inready[%0d]", k), 32'(inrdy[k]), 32'(sz < DEPTH));
          check($sformatf("almostfull[%0d]", k), 32'(af[k]), 32'(sz >= 14));
          check($sformatf("almostempty[%0d]", k), 32'(ae[k]), 32'(sz <= 2));
          check($sformatf("wrack[%0d]", k), 32'(wack[k]), 32'(m_wack[k]));
          check($sformatf("overflow[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
          check($sformatf("underflow[%0d]", k), 32'(udf[k]), 32'(m_udf[k]));
          if (k == 0) begin
            check("outvalid[0]", 32'(outv[0]), 32'(sz > 0));
            if (sz > 0) check("outdata[0]", 32'(outd[0]), 32'(mq[0][0]));
          end else begin
            check("outvalid[1]", 32'(outv[1]), 32'(m_sov[1]));
            if (m_sod_known[1]) check("outdata[1]", 32'(outd[1]), 32'(m_sod[1]));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] last;
    int pw, pr;
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      ind[k] = '0; inv[k] = 0; ordy[k] = 0; clr[k] = 0;
    end
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1;
    tick();
    check("rst_count", 32'(cnt[0]), 0);
    check("rst_inready", 32'(inrdy[0]), 1);
    check("rst_outvalid", 32'(outv[0]), 0);
    check("rst_almostempty", 32'(ae[0]), 1);
    check("rst_overflow", 32'(ovf[0]), 0);
    check("rst_wrack", 32'(wack[0]), 0);
    check("rst_std_outvalid", 32'(outv[1]), 0);

    // Single write and pop in FWFT mode
    ind[0] = 8'h21; inv[0] = 1;
    tick();
    inv[0] = 0;
    check("w21_wrack", 32'(wack[0]), 1);
    check("w21_outvalid", 32'(outv[0]), 1);
    check("w21_outdata", 32'(outd[0]), 32'h21);
    check("w21_count", 32'(cnt[0]), 1);
    tick();
    check("w21_wrack_drop", 32'(wack[0]), 0);
    ordy[0] = 1;
    tick();
    ordy[0] = 0;
    check("pop21_outvalid", 32'(outv[0]), 0);
    check("pop21_count", 32'(cnt[0]), 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      ind[0] = 8'(i); inv[0] = 1;
      tick();
      if (i == 12) check("fill13_almostfull", 32'(af[0]), 0);
      if (i == 13) check("fill14_almostfull", 32'(af[0]), 1);
    end
    check("full_count", 32'(cnt[0]), 16);
    check("full_inready", 32'(inrdy[0]), 0);
    ind[0] = 8'hAA;
    tick();
    inv[0] = 0;
    check("ovf_set", 32'(ovf[0]), 1);
    check("ovf_count", 32'(cnt[0]), 16);
    check("ovf_no_wrack", 32'(wack[0]), 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(outd[0]), 32'(i));
      ordy[0] = 1;
      tick();
    end
    ordy[0] = 0;
    check("drained_count", 32'(cnt[0]), 0);
    clr[0] = 1;
    tick();
    clr[0] = 0;
    check("ovf_cleared", 32'(ovf[0]), 0);

    // Streaming at Count==1 across several pointer wraps
    ind[0] = 8'h77; inv[0] = 1; last = 8'h77;
    tick();
    for (int i = 0; i < 40; i++) begin
      check("stream_head", 32'(outd[0]), 32'(last));
      check("stream_count", 32'(cnt[0]), 1);
      ind[0] = 8'($urandom); last = ind[0];
      inv[0] = 1; ordy[0] = 1;
      tick();
    end
    inv[0] = 0; ordy[0] = 0;
    check("stream_end_count", 32'(cnt[0]), 1);
    check("stream_end_head", 32'(outd[0]), 32'(last));
    ordy[0] = 1;
    tick();
    ordy[0] = 0;

    // Standard read mode
    ind[1] = 8'h55; inv[1] = 1;
    tick();
    ind[1] = 8'h66;
    tick();
    inv[1] = 0; ordy[1] = 1;
    tick();
    ordy[1] = 0;
    check("std_rd55_valid", 32'(outv[1]), 1);
    check("std_rd55_data", 32'(outd[1]), 32'h55);
    tick();
    check("std_rd55_valid_drop", 32'(outv[1]), 0);
    check("std_rd55_hold", 32'(outd[1]), 32'h55);
    ordy[1] = 1;
    tick();
    check("std_rd66_data", 32'(outd[1]), 32'h66);
    tick();
    ordy[1] = 0;
    check("std_udf_set", 32'(udf[1]), 1);
    check("std_udf_outvalid", 32'(outv[1]), 0);
    clr[1] = 1;
    tick();
    clr[1] = 0;
    check("std_udf_cleared", 32'(udf[1]), 0);

    // Reset during an active write with Count==5
    for (int i = 0; i < 5; i++) begin
      ind[0] = 8'(8'h30 + i); inv[0] = 1;
      tick();
    end
    check("pre_reset_count", 32'(cnt[0]), 5);
    ind[0] = 8'h99; rst_n = 0;
    tick();
    rst_n = 1; inv[0] = 0;
    check("midrst_count", 32'(cnt[0]), 0);
    check("midrst_outvalid", 32'(outv[0]), 0);
    check("midrst_wrack", 32'(wack[0]), 0);
    tick();
    check("midrst_wrack_after", 32'(wack[0]), 0);

    // Randomized traffic with shifting write/read pressure
    pw = 50; pr = 50;
    for (int c = 0; c < 2400; c++) begin
      if (c % 150 == 0) begin
        pw = $urandom_range(95, 5);
        pr = $urandom_range(95, 5);
      end
      rst_n = ($urandom_range(599) != 0);
      for (int k = 0; k < 2; k++) begin
        ind[k]  = 8'($urandom);
        inv[k]  = ($urandom_range(99) < pw);
        ordy[k] = ($urandom_range(99) < pr);
        clr[k]  = ($urandom_range(31) == 0);
      end
      tick();
    end
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      inv[k] = 0; ordy[k] = 0; clr[k] = 0;
    end
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
